// File: rtl/rv_pkg.sv
// Shared RISC-V MEM-stage definitions: opcodes, load/store funct3 codes,
// the canonical NOP and the memory-access FSM state type.
package rv_pkg;

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Load/store lane logic: byte enables and replicated write data for stores,
// lane selection plus sign/zero extension for loads.
module lsu_align
    import rv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Size comes from funct3[1:0] so loads and stores share one enable rule.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = rdata[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3_e'(funct3))
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    ld_data = rdata;
            F3_BU:   ld_data = {24'h000000, ld_byte};
            F3_HU:   ld_data = {16'h0000, ld_half};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage with req/ack data-memory handshake, timeout abort and MEM/WB register.
// Optional build macro MEM_MISALIGN_CHK_EN rejects misaligned halfword/word accesses.
module mem_stage
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] alu_mem_i,
    input  logic [31:0] rs2_mem_i,
    input  logic [31:0] pc4_mem_i,
    input  logic        MemRW_mem_i,
    input  logic [1:0]  WBSel_mem_i,
    input  logic        RegWEn_mem_i,
    input  logic [4:0]  rsW_mem_i,
    input  logic [31:0] inst_mem_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic [31:0] alu_wb_o,
    output logic [31:0] ld_wb_o,
    output logic [31:0] pc4_wb_o,
    output logic [1:0]  WBSel_wb_o,
    output logic        RegWEn_wb_o,
    output logic [4:0]  rsW_wb_o,
    output logic [31:0] inst_wb_o
);

    mem_state_e  state, state_n;
    logic [7:0]  cnt;
    logic        is_load, is_store, is_access;
    logic        misalign, timeout, capture;
    logic [31:0] ld_data;

    assign is_load   = (inst_mem_i[6:0] == OP_LOAD);
    assign is_store  = (inst_mem_i[6:0] == OP_STORE);
    assign is_access = is_load | is_store;
    assign timeout   = (cnt == 8'(TIMEOUT_CYC));

`ifdef MEM_MISALIGN_CHK_EN
    always_comb begin
        misalign = 1'b0;
        if (is_access) begin
            case (inst_mem_i[13:12])
                2'b01:   misalign = alu_mem_i[0];
                2'b10:   misalign = |alu_mem_i[1:0];
                default: misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    lsu_align u_lsu_align (
        .funct3     (inst_mem_i[14:12]),
        .addr_lo    (alu_mem_i[1:0]),
        .store_data (rs2_mem_i),
        .rdata      (dmem_rdata_i),
        .be         (dmem_be_o),
        .wdata      (dmem_wdata_o),
        .ld_data    (ld_data)
    );

    assign dmem_addr_o = {alu_mem_i[31:2], 2'b00};
    assign dmem_we_o   = dmem_req_o & (is_store | MemRW_mem_i & is_access);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state_n == WAIT)
                cnt <= (state == IDLE) ? 8'd1 : cnt + 8'd1;
            else
                cnt <= '0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (is_access && !misalign && !dmem_ack_i) state_n = WAIT;
            WAIT: if (dmem_ack_i || timeout) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are gated by reset so a pending request vanishes the moment reset asserts.
    always_comb begin
        dmem_req_o = 1'b0;
        stall_o    = 1'b0;
        bus_err_o  = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!is_access) begin
                    capture = 1'b1;
                end else if (misalign) begin
                    bus_err_o = 1'b1;
                end else begin
                    dmem_req_o = 1'b1;
                    capture    = dmem_ack_i;
                    stall_o    = !dmem_ack_i;
                end
            end
            WAIT: begin
                dmem_req_o = 1'b1;
                if (dmem_ack_i)   capture   = 1'b1;
                else if (timeout) bus_err_o = 1'b1;
                else              stall_o   = 1'b1;
            end
            default: ;
        endcase
        if (!rst_ni) begin
            dmem_req_o = 1'b0;
            stall_o    = 1'b0;
            bus_err_o  = 1'b0;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            alu_wb_o    <= '0;
            ld_wb_o     <= '0;
            pc4_wb_o    <= '0;
            WBSel_wb_o  <= '0;
            RegWEn_wb_o <= 1'b0;
            rsW_wb_o    <= '0;
            inst_wb_o   <= NOP_INST;
        end else if (capture) begin
            alu_wb_o    <= alu_mem_i;
            ld_wb_o     <= is_load ? ld_data : '0;
            pc4_wb_o    <= pc4_mem_i;
            WBSel_wb_o  <= WBSel_mem_i;
            RegWEn_wb_o <= RegWEn_mem_i;
            rsW_wb_o    <= rsW_mem_i;
            inst_wb_o   <= inst_mem_i;
        end else begin
            RegWEn_wb_o <= 1'b0;
            inst_wb_o   <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores push expected bus and
// MEM/WB transactions; a monitor pops and compares them as the DUT presents them.
module tb_mem_stage;
    import rv_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_i, rs2_i, pc4_i, inst_i, rdata_i;
    logic        memrw_i, regwen_i, ack_i;
    logic [1:0]  wbsel_i;
    logic [4:0]  rsw_i;
    logic        dmem_req, dmem_we, stall, bus_err, regwen_wb;
    logic [31:0] dmem_addr, dmem_wdata, alu_wb, ld_wb, pc4_wb, inst_wb;
    logic [3:0]  dmem_be;
    logic [1:0]  wbsel_wb;
    logic [4:0]  rsw_wb;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alu_mem_i(alu_i), .rs2_mem_i(rs2_i), .pc4_mem_i(pc4_i),
        .MemRW_mem_i(memrw_i), .WBSel_mem_i(wbsel_i), .RegWEn_mem_i(regwen_i),
        .rsW_mem_i(rsw_i), .inst_mem_i(inst_i),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_ack_i(ack_i), .dmem_rdata_i(rdata_i),
        .stall_o(stall), .bus_err_o(bus_err),
        .alu_wb_o(alu_wb), .ld_wb_o(ld_wb), .pc4_wb_o(pc4_wb),
        .WBSel_wb_o(wbsel_wb), .RegWEn_wb_o(regwen_wb), .rsW_wb_o(rsw_wb),
        .inst_wb_o(inst_wb)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        chk_ld;
        logic [4:0]  rd;
        logic        regwen;
        logic [1:0]  wbsel;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {17'b0, f3, rd, op};
    endfunction

    task automatic exp_bus(input logic [31:0] addr, input logic [3:0] be, input logic we,
                           input logic [31:0] wdata);
        bus_t b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    task automatic exp_wb(input logic [31:0] inst, input logic [31:0] alu, input logic [4:0] rd,
                          input logic regwen, input logic [1:0] wbsel, input logic chk_ld,
                          input logic [31:0] ld);
        wb_t w;
        w.inst = inst; w.alu = alu; w.rd = rd; w.regwen = regwen;
        w.wbsel = wbsel; w.chk_ld = chk_ld; w.ld = ld;
        wb_q.push_back(w);
    endtask

    task automatic nop();
        inst_i = NOP_INST; alu_i = '0; rs2_i = '0; pc4_i = '0;
        memrw_i = 1'b0; regwen_i = 1'b0; wbsel_i = 2'b01; rsw_i = '0;
    endtask

    // Present one instruction until the stage accepts it; ack_after < 0 means never ack.
    task automatic run(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic regwen, input logic [1:0] wbsel,
                       input int ack_after, input logic [31:0] rdata,
                       output int stalls, output int errs);
        logic done;
        done = 1'b0; stalls = 0; errs = 0;
        inst_i = inst; alu_i = alu; rs2_i = rs2; pc4_i = alu + 32'd4;
        rsw_i = rd; regwen_i = regwen; wbsel_i = wbsel;
        memrw_i = (inst[6:0] == OP_STORE); rdata_i = rdata;
        for (int c = 0; c < 300 && !done; c++) begin
            ack_i = (c == ack_after);
            @(negedge clk);
            if (stall) stalls++;
            if (bus_err) errs++;
            done = !stall;
            @(posedge clk); #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL run_timeout: stage still stalling after 300 cycles, required release");
        end
        ack_i = 1'b0;
        nop();
    endtask

    initial begin : monitor
        bus_t b;
        wb_t  w;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (dmem_req && ack_i) begin
                    if (bus_q.size() == 0) begin
                        n_total++;
                        $display("FAIL bus_unexpected: got access addr 0x%08h, required none", dmem_addr);
                    end else begin
                        b = bus_q.pop_front();
                        chk("bus_addr", dmem_addr, b.addr);
                        chk("bus_be", {28'd0, dmem_be}, {28'd0, b.be});
                        chk("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
                        if (b.we) chk("bus_wdata", dmem_wdata, b.wdata);
                    end
                end
                if (inst_wb != NOP_INST) begin
                    if (wb_q.size() == 0) begin
                        n_total++;
                        $display("FAIL wb_unexpected: got inst_wb 0x%08h, required bubble", inst_wb);
                    end else begin
                        w = wb_q.pop_front();
                        chk("wb_inst", inst_wb, w.inst);
                        chk("wb_alu", alu_wb, w.alu);
                        chk("wb_pc4", pc4_wb, w.alu + 32'd4);
                        chk("wb_rd", {27'd0, rsw_wb}, {27'd0, w.rd});
                        chk("wb_regwen", {31'd0, regwen_wb}, {31'd0, w.regwen});
                        chk("wb_wbsel", {30'd0, wbsel_wb}, {30'd0, w.wbsel});
                        if (w.chk_ld) chk("wb_ld", ld_wb, w.ld);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int st, er;
        logic [31:0] i;
        rst_n = 1'b0; ack_i = 1'b0; rdata_i = '0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_inst_wb", inst_wb, 32'h00000013);
        chk("rst_regwen_wb", {31'd0, regwen_wb}, 32'd0);
        chk("rst_alu_wb", alu_wb, 32'd0);
        chk("rst_ld_wb", ld_wb, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LW x5 zero-wait
        i = mk(OP_LOAD, 3'b010, 5'd5);
        exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
        exp_wb(i, 32'h100, 5'd5, 1'b1, 2'b00, 1'b1, 32'hDEADBEEF);
        run(i, 32'h100, 32'h11111111, 5'd5, 1'b1, 2'b00, 0, 32'hDEADBEEF, st, er);
        chk("lw_stalls", st, 0);
        chk("lw_errs", er, 0);

        // LB with three wait cycles
        i = mk(OP_LOAD, 3'b000, 5'd6);
        exp_bus(32'h100, 4'b1000, 1'b0, 32'h0);
        exp_wb(i, 32'h103, 5'd6, 1'b1, 2'b00, 1'b1, 32'hFFFFFF80);
        run(i, 32'h103, 32'h0, 5'd6, 1'b1, 2'b00, 3, 32'h80123456, st, er);
        chk("lb_stalls", st, 3);
        chk("lb_errs", er, 0);

        // SH upper half
        i = mk(OP_STORE, 3'b001, 5'd0);
        exp_bus(32'h200, 4'b1100, 1'b1, 32'hABCDABCD);
        exp_wb(i, 32'h202, 5'd0, 1'b0, 2'b01, 1'b0, 32'h0);
        run(i, 32'h202, 32'h1234ABCD, 5'd0, 1'b0, 2'b01, 1, 32'h0, st, er);
        chk("sh_stalls", st, 1);

        // SB lane 1
        i = mk(OP_STORE, 3'b000, 5'd0);
        exp_bus(32'h200, 4'b0010, 1'b1, 32'hA5A5A5A5);
        exp_wb(i, 32'h201, 5'd0, 1'b0, 2'b01, 1'b0, 32'h0);
        run(i, 32'h201, 32'hFFFFFFA5, 5'd0, 1'b0, 2'b01, 0, 32'h0, st, er);

        // LHU / LH / LBU extension
        i = mk(OP_LOAD, 3'b101, 5'd10);
        exp_bus(32'h100, 4'b1100, 1'b0, 32'h0);
        exp_wb(i, 32'h102, 5'd10, 1'b1, 2'b00, 1'b1, 32'h00008001);
        run(i, 32'h102, 32'h0, 5'd10, 1'b1, 2'b00, 0, 32'h80017FFF, st, er);
        i = mk(OP_LOAD, 3'b001, 5'd11);
        exp_bus(32'h100, 4'b0011, 1'b0, 32'h0);
        exp_wb(i, 32'h100, 5'd11, 1'b1, 2'b00, 1'b1, 32'hFFFF8001);
        run(i, 32'h100, 32'h0, 5'd11, 1'b1, 2'b00, 2, 32'h12348001, st, er);
        i = mk(OP_LOAD, 3'b100, 5'd12);
        exp_bus(32'h100, 4'b0010, 1'b0, 32'h0);
        exp_wb(i, 32'h101, 5'd12, 1'b1, 2'b00, 1'b1, 32'h000000F0);
        run(i, 32'h101, 32'h0, 5'd12, 1'b1, 2'b00, 0, 32'h0000F000, st, er);

        // Non-access passes straight through
        i = mk(7'b0110011, 3'b000, 5'd7);
        exp_wb(i, 32'hCAFE0000, 5'd7, 1'b1, 2'b01, 1'b0, 32'h0);
        run(i, 32'hCAFE0000, 32'h0, 5'd7, 1'b1, 2'b01, -1, 32'h0, st, er);
        chk("alu_stalls", st, 0);

        // Timeout abort, then the next instruction proceeds
        i = mk(OP_LOAD, 3'b010, 5'd13);
        run(i, 32'h300, 32'h0, 5'd13, 1'b1, 2'b00, -1, 32'h0, st, er);
        chk("tmo_stalls", st, int'(TMO));
        chk("tmo_errs", er, 1);
        @(negedge clk);
        chk("tmo_bubble_regwen", {31'd0, regwen_wb}, 32'd0);
        chk("tmo_bubble_inst", inst_wb, NOP_INST);
        @(posedge clk); #1;
        i = mk(7'b0110011, 3'b000, 5'd8);
        exp_wb(i, 32'h12345678, 5'd8, 1'b1, 2'b01, 1'b0, 32'h0);
        run(i, 32'h12345678, 32'h0, 5'd8, 1'b1, 2'b01, -1, 32'h0, st, er);
        chk("post_tmo_stalls", st, 0);

        // Reset during WAIT, then a late ack
        inst_i = mk(OP_LOAD, 3'b010, 5'd14); alu_i = 32'h400; pc4_i = 32'h404;
        regwen_i = 1'b1; rsw_i = 5'd14; wbsel_i = 2'b00; ack_i = 1'b0;
        @(negedge clk);
        chk("rw_req", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_wait_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rw_req_in_reset", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; nop(); ack_i = 1'b1;
        @(negedge clk);
        chk("rw_late_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("rw_late_ack_stall", {31'd0, stall}, 32'd0);
        chk("rw_alu_wb", alu_wb, 32'd0);
        chk("rw_inst_wb", inst_wb, NOP_INST);
        @(posedge clk); #1;
        ack_i = 1'b0;
        i = mk(OP_LOAD, 3'b010, 5'd15);
        exp_bus(32'h500, 4'b1111, 1'b0, 32'h0);
        exp_wb(i, 32'h500, 5'd15, 1'b1, 2'b00, 1'b1, 32'h01020304);
        run(i, 32'h500, 32'h0, 5'd15, 1'b1, 2'b00, 0, 32'h01020304, st, er);
        chk("post_rst_stalls", st, 0);

        // Misaligned LW
        i = mk(OP_LOAD, 3'b010, 5'd9);
`ifdef MEM_MISALIGN_CHK_EN
        run(i, 32'h101, 32'h0, 5'd9, 1'b1, 2'b00, 0, 32'h0BADF00D, st, er);
        chk("mis_errs", er, 1);
        chk("mis_stalls", st, 0);
`else
        exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
        exp_wb(i, 32'h101, 5'd9, 1'b1, 2'b00, 1'b1, 32'h0BADF00D);
        run(i, 32'h101, 32'h0, 5'd9, 1'b1, 2'b00, 0, 32'h0BADF00D, st, er);
        chk("mis_errs", er, 0);
        chk("mis_stalls", st, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("bus_q_drained", bus_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
